boolfn_eval_sched: RTL and testbench
====================================

Name: boolfn_eval_sched

Overview:
- Shares one combinational 3-input Boolean evaluator, y = a'b'c' + b'c' + a'c' + a'b', among NREQ requesters.
- Arbitration is round-robin, and each requester uses a valid/ready handshake.
- A built-in sweep sequencer drives all 8 input codes through the evaluator and captures an 8-bit truth table for self-check.
- The block sits between requesting agents and the evaluator core and is the evaluator's only driver.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, $clog2(NREQ), width of the requester ID

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_abc  in  3*NREQ  per-requester operand {a,b,c}; requester i uses bits [3i+2:3i]
req_ready  out  NREQ  one-hot grant; handshake when req_valid[i] & req_ready[i]
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_y  out  1  evaluator result
rsp_id  out  IDW  requester index of the response
rsp_abc  out  3  operand that produced rsp_y
sweep_start  in  1  single-cycle pulse; starts a truth-table sweep
sweep_busy  out  1  high while a sweep is running
sweep_done  out  1  one-cycle pulse when the sweep completes
truth_table  out  8  bit k = y for input {a,b,c} = k

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_y=0, rsp_id=0, rsp_abc=0, sweep_busy=0, sweep_done=0, truth_table=8'h00, RR pointer=NREQ-1, FSM=ARB.
- Asserting reset mid-operation aborts everything, including an in-flight sweep and a held response, and restores the reset values.
- Evaluator: y=1 iff at most one of a,b,c is 1. The expected truth table is 8'h17 (codes 0,1,2,4).
- FSM has two states, ARB and SWEEP.
- ARB state, grant rule:
  - A grant is allowed when the response slot is free: rsp_valid=0, or rsp_valid & rsp_ready in the same cycle.
  - The winner is the first requester i with req_valid[i]=1, searching from pointer+1 modulo NREQ.
- ARB state, grant timing:
  - req_ready is combinational from req_valid, the pointer and slot state; it is one-hot or zero.
  - On a grant, the evaluator sees the winner's operand that cycle.
  - rsp_y/rsp_id/rsp_abc are registered at the clock edge; rsp_valid=1 in the next cycle. Latency is 1 cycle from handshake to response.
  - The pointer updates to the winner index.
- Response hold: while rsp_valid & !rsp_ready, the response registers hold stable and no grant is issued (backpressure). Draining and a new grant in the same cycle give back-to-back responses, for a throughput of 1 per cycle.
- ARB -> SWEEP: taken on sweep_start.
  - sweep_start has priority over requests: no grant in that cycle.
  - truth_table clears to 0; the sweep index is 0; sweep_busy=1 from the next cycle.
- SWEEP state:
  - req_ready=0 throughout.
  - The evaluator is driven by the sweep index k=0..7, one code per cycle; truth_table[k] <= y.
  - After k=7 is written: FSM returns to ARB, sweep_busy=0, and sweep_done pulses for 1 cycle. sweep_busy lasts exactly 8 cycles.
- Sweep boundary cases:
  - sweep_start while busy is ignored.
  - A response held at sweep start stays valid and can be drained by rsp_ready during SWEEP.
  - The RR pointer is unchanged by a sweep.
- truth_table holds its value until the next sweep_start or reset.
- Index wrap: the sweep index is 3 bits and is not used beyond 7. The RR search wraps modulo NREQ.
- No combinational path from rsp_ready to rsp_* outputs. req_ready depends combinationally on rsp_ready, which is permitted.

Decomposition:
- Package boolfn_pkg:
  - abc_t (logic [2:0]).
  - localparam TT_EXPECTED = 8'h17.
  - FSM enum sched_state_e {ST_ARB, ST_SWEEP}.
- Sub-module boolfn_core: a purely combinational evaluator with inputs a,b,c and output y, instantiated once.
- The round-robin pick is a function inside boolfn_eval_sched, not a separate module.

Test Plan:
- Reset, then a sweep_start pulse: sweep_busy is high for 8 cycles, sweep_done pulses once, truth_table=8'h17.
- Reset, then req_valid=4'b1111, all operands 3'b000, rsp_ready=1: grants go 0,1,2,3,0 on consecutive cycles, rsp_id follows one cycle later, and rsp_y=1 each time.
- Only requester 2 valid with abc=3'b011: req_ready=4'b0100 that cycle; next cycle rsp_valid=1, rsp_id=2, rsp_y=0, rsp_abc=3'b011.
- Backpressure: hold rsp_ready=0 for 3 cycles with requesters 0 and 1 valid. The response is stable and req_ready=0 throughout. On the cycle rsp_ready=1, the next grant goes to requester 1 and its response appears the following cycle.
- sweep_start in the same cycle as req_valid=4'b0001: no grant that cycle, req_ready=0 for 8 cycles. After sweep_done, requester 0 is granted, and truth_table=8'h17.
- Assert rst_n=0 during sweep cycle 4: all outputs and truth_table return to 0 immediately. After release, the first grant goes to requester 0.

Source files
------------

// File: rtl/boolfn_pkg.sv
// Shared types and constants for the shared Boolean evaluator and its scheduler.
// The evaluator returns 1 when at most one of its three inputs is set.
package boolfn_pkg;

    typedef logic [2:0] abc_t;

    localparam logic [7:0] TT_EXPECTED = 8'h17;

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_SWEEP = 1'b1
    } sched_state_e;

endpackage

// File: rtl/boolfn_core.sv
// Combinational evaluator y = a'b'c' + b'c' + a'c' + a'b'.
// This reduces to "no two inputs are high at the same time".
module boolfn_core (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y
);

    assign y = ~((a & b) | (a & c) | (b & c));

endmodule

// File: rtl/boolfn_eval_sched.sv
// Round-robin scheduler that shares one boolfn_core among NREQ requesters.
// It also holds an 8-code sweep sequencer that captures the evaluator's truth table.
module boolfn_eval_sched
    import boolfn_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [3*NREQ-1:0] req_abc,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_y,
    output logic [IDW-1:0]    rsp_id,
    output logic [2:0]        rsp_abc,
    input  logic              sweep_start,
    output logic              sweep_busy,
    output logic              sweep_done,
    output logic [7:0]        truth_table
);

    sched_state_e   state_reg;
    logic [IDW-1:0] ptr_reg;
    abc_t           sweep_idx_reg;
    logic [7:0]     tt_reg;
    logic           rsp_valid_reg;
    logic           rsp_y_reg;
    logic [IDW-1:0] rsp_id_reg;
    abc_t           rsp_abc_reg;
    logic           sweep_done_reg;

    abc_t           req_abc_arr [2**IDW];
    logic [IDW:0]   pick;
    logic           pick_found;
    logic [IDW-1:0] win_idx;
    logic           slot_free;
    logic           grant;
    abc_t           eval_abc;
    logic           eval_y;

    // First valid requester after ptr, wrapping modulo NREQ; MSB flags a hit.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] valid,
                                             input logic [IDW-1:0]  ptr);
        logic           found;
        logic [IDW-1:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int j = 1; j <= NREQ; j++) begin
            int cand;
            cand = (int'(ptr) + j) % NREQ;
            if (!found && valid[cand]) begin
                found = 1'b1;
                idx   = IDW'(cand);
            end
        end
        return {found, idx};
    endfunction

    // Unused slots of the power-of-two operand table read as zero.
    for (genvar gi = 0; gi < 2**IDW; gi++) begin : g_abc
        if (gi < NREQ) begin : g_used
            assign req_abc_arr[gi] = req_abc[3*gi +: 3];
        end else begin : g_pad
            assign req_abc_arr[gi] = '0;
        end
    end

    assign pick       = rr_pick(req_valid, ptr_reg);
    assign pick_found = pick[IDW];
    assign win_idx    = pick[IDW-1:0];
    assign slot_free  = !rsp_valid_reg || rsp_ready;
    // A sweep request wins over any pending request in the same cycle.
    assign grant      = rst_n && (state_reg == ST_ARB) && !sweep_start && slot_free && pick_found;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
        assign req_ready[gi] = grant && (win_idx == IDW'(gi));
    end

    assign eval_abc = (state_reg == ST_SWEEP) ? sweep_idx_reg : req_abc_arr[win_idx];

    boolfn_core u_core (
        .a (eval_abc[2]),
        .b (eval_abc[1]),
        .c (eval_abc[0]),
        .y (eval_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_ARB;
            ptr_reg        <= IDW'(NREQ - 1);
            sweep_idx_reg  <= '0;
            tt_reg         <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_y_reg      <= 1'b0;
            rsp_id_reg     <= '0;
            rsp_abc_reg    <= '0;
            sweep_done_reg <= 1'b0;
        end else begin
            sweep_done_reg <= 1'b0;

            if (grant) begin
                rsp_valid_reg <= 1'b1;
                rsp_y_reg     <= eval_y;
                rsp_id_reg    <= win_idx;
                rsp_abc_reg   <= eval_abc;
                ptr_reg       <= win_idx;
            end else if (rsp_ready) begin
                rsp_valid_reg <= 1'b0;
            end

            case (state_reg)
                ST_ARB: begin
                    if (sweep_start) begin
                        state_reg     <= ST_SWEEP;
                        tt_reg        <= '0;
                        sweep_idx_reg <= '0;
                    end
                end
                ST_SWEEP: begin
                    tt_reg[sweep_idx_reg] <= eval_y;
                    sweep_idx_reg         <= sweep_idx_reg + 3'd1;
                    if (sweep_idx_reg == 3'd7) begin
                        state_reg      <= ST_ARB;
                        sweep_done_reg <= 1'b1;
                    end
                end
                default: state_reg <= ST_ARB;
            endcase
        end
    end

    assign rsp_valid   = rsp_valid_reg;
    assign rsp_y       = rsp_y_reg;
    assign rsp_id      = rsp_id_reg;
    assign rsp_abc     = rsp_abc_reg;
    assign sweep_busy  = (state_reg == ST_SWEEP);
    assign sweep_done  = sweep_done_reg;
    assign truth_table = tt_reg;

endmodule

// File: tb/tb_boolfn_eval_sched.sv
// Directed bench for boolfn_eval_sched: a response scoreboard for the arbiter plus sweep,
// backpressure and reset-abort scenarios.
module tb_boolfn_eval_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [3*NREQ-1:0] req_abc;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_y;
    logic [IDW-1:0]    rsp_id;
    logic [2:0]        rsp_abc;
    logic              sweep_start;
    logic              sweep_busy;
    logic              sweep_done;
    logic [7:0]        truth_table;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [2:0]     abc;
        logic           y;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    boolfn_eval_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_abc     (req_abc),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_y       (rsp_y),
        .rsp_id      (rsp_id),
        .rsp_abc     (rsp_abc),
        .sweep_start (sweep_start),
        .sweep_busy  (sweep_busy),
        .sweep_done  (sweep_done),
        .truth_table (truth_table)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Reference evaluator: true when at most one input bit is set.
    function automatic logic y_model(input logic [2:0] abc);
        return ($countones(abc) <= 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_abc(input int i, input logic [2:0] v);
        req_abc[3*i +: 3] = v;
    endtask

    task automatic push_exp(input int id, input logic [2:0] abc);
        exp_t e;
        e.id  = IDW'(id);
        e.abc = abc;
        e.y   = y_model(abc);
        sb.push_back(e);
    endtask

    task automatic compare_rsp(input string tag);
        exp_t e;
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_sb observed=response expected=none_pending", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_id"},  32'(rsp_id),  32'(e.id));
            chk({tag, "_abc"}, 32'(rsp_abc), 32'(e.abc));
            chk({tag, "_y"},   32'(rsp_y),   32'(e.y));
            $display("rsp %s: id=%0d abc=%03b y=%0d (exp id=%0d abc=%03b y=%0d)",
                     tag, rsp_id, rsp_abc, rsp_y, e.id, e.abc, e.y);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_y"},     32'(rsp_y),     32'd0);
        chk({tag, "_rsp_id"},    32'(rsp_id),    32'd0);
        chk({tag, "_rsp_abc"},   32'(rsp_abc),   32'd0);
        chk({tag, "_busy"},      32'(sweep_busy), 32'd0);
        chk({tag, "_done"},      32'(sweep_done), 32'd0);
        chk({tag, "_tt"},        32'(truth_table), 32'd0);
    endtask

    initial begin
        logic [7:0] tt_exp;
        logic [7:0] tt_part;
        int busy_cnt;
        int done_cnt;

        tt_exp  = '0;
        tt_part = '0;
        for (int k = 0; k < 8; k++) begin
            tt_exp[k] = y_model(3'(k));
            if (k < 4) tt_part[k] = y_model(3'(k));
        end

        rst_n       = 1'b0;
        req_valid   = '0;
        req_abc     = '0;
        rsp_ready   = 1'b0;
        sweep_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        chk("tt_model_const", 32'(tt_exp), 32'h17);
        rst_n = 1'b1;
        tick();

        // Sweep from idle: 8 busy cycles, one done pulse, full truth table.
        sweep_start = 1'b1;
        #1;
        chk("sw1_start_ready", 32'(req_ready), 32'd0);
        tick();
        sweep_start = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (sweep_busy) busy_cnt++;
            if (sweep_done) done_cnt++;
            tick();
        end
        chk("sw1_busy_cycles", 32'(busy_cnt), 32'd8);
        chk("sw1_done_pulses", 32'(done_cnt), 32'd1);
        chk("sw1_tt", 32'(truth_table), 32'(tt_exp));
        $display("sweep1: busy=%0d done=%0d tt=%02h", busy_cnt, done_cnt, truth_table);

        // All four requesting: rotation 0,1,2,3,0 with back-to-back responses.
        req_valid = 4'b1111;
        req_abc   = '0;
        rsp_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            #1;
            if (n > 0) compare_rsp("rr");
            chk("rr_ready", 32'(req_ready), 32'(1 << (n % NREQ)));
            push_exp(n % NREQ, 3'b000);
            tick();
        end
        req_valid = '0;
        #1;
        compare_rsp("rr_last");
        chk("rr_idle_ready", 32'(req_ready), 32'd0);
        tick();
        chk("rr_drained", 32'(rsp_valid), 32'd0);

        // Single requester 2 with a two-hot operand.
        req_valid = 4'b0100;
        set_abc(2, 3'b011);
        #1;
        chk("r2_ready", 32'(req_ready), 32'b0100);
        push_exp(2, 3'b011);
        tick();
        req_valid = '0;
        #1;
        compare_rsp("r2");
        tick();

        // Backpressure: response held for 3 cycles, then requester 1 wins.
        req_valid = 4'b0011;
        set_abc(0, 3'b001);
        set_abc(1, 3'b110);
        rsp_ready = 1'b0;
        #1;
        chk("bp_first_ready", 32'(req_ready), 32'b0001);
        push_exp(0, 3'b001);
        tick();
        for (int c = 0; c < 3; c++) begin
            chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
            chk("bp_hold_id",    32'(rsp_id),    32'd0);
            chk("bp_hold_abc",   32'(rsp_abc),   32'b001);
            chk("bp_hold_y",     32'(rsp_y),     32'd1);
            chk("bp_hold_ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        compare_rsp("bp_drain");
        chk("bp_next_ready", 32'(req_ready), 32'b0010);
        push_exp(1, 3'b110);
        tick();
        req_valid = '0;
        #1;
        compare_rsp("bp_next");
        tick();

        // Sweep request collides with a request: sweep wins, grant waits.
        req_valid   = 4'b0001;
        set_abc(0, 3'b100);
        sweep_start = 1'b1;
        #1;
        chk("sw2_start_ready", 32'(req_ready), 32'd0);
        tick();
        sweep_start = 1'b0;
        chk("sw2_no_grant", 32'(rsp_valid), 32'd0);
        for (int c = 0; c < 8; c++) begin
            chk("sw2_ready_low", 32'(req_ready), 32'd0);
            chk("sw2_busy",      32'(sweep_busy), 32'd1);
            tick();
        end
        chk("sw2_done",       32'(sweep_done), 32'd1);
        chk("sw2_busy_end",   32'(sweep_busy), 32'd0);
        chk("sw2_tt",         32'(truth_table), 32'(tt_exp));
        chk("sw2_after_ready", 32'(req_ready), 32'b0001);
        push_exp(0, 3'b100);
        tick();
        req_valid = '0;
        chk("sw2_done_pulse", 32'(sweep_done), 32'd0);
        #1;
        compare_rsp("sw2_grant");
        tick();

        // Held response carried into a sweep, then reset aborts mid-sweep.
        req_valid = 4'b0010;
        set_abc(1, 3'b101);
        rsp_ready = 1'b0;
        #1;
        chk("rst_pre_ready", 32'(req_ready), 32'b0010);
        push_exp(1, 3'b101);
        tick();
        req_valid   = '0;
        sweep_start = 1'b1;
        #1;
        compare_rsp("rst_held");
        tick();
        sweep_start = 1'b0;
        repeat (4) tick();
        chk("rst_mid_busy",  32'(sweep_busy), 32'd1);
        chk("rst_mid_held",  32'(rsp_valid), 32'd1);
        chk("rst_mid_tt",    32'(truth_table), 32'(tt_part));
        req_valid = 4'b1111;
        req_abc   = '0;
        rst_n     = 1'b0;
        #1;
        chk_all_zero("rst_abort");
        sb.delete();
        tick();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        #1;
        chk("rst_first_ready", 32'(req_ready), 32'b0001);
        push_exp(0, 3'b000);
        tick();
        req_valid = '0;
        #1;
        compare_rsp("rst_first");
        tick();
        chk("end_sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
